rng_draw_ctrl: RTL and testbench

Sequencer for the random-number generator datapath. It takes the two raw push-button levels (start key, draw key) and conditions them with a synchronizer, a debouncer and a rising-edge detector. A state machine then seeds and steps an external LFSR, samples its output into decimal digit slots by rejection sampling, and reports progress to the display logic. It sits between the board keys and the LFSR/7-segment path and replaces the plain level-based press counter.

---
 rtl/rng_draw_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rng_draw_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_draw_ctrl.sv
// rng_draw_ctrl: key conditioning plus draw sequencer for the LFSR digit path.
// Conditions the start and draw keys (2-flop sync, optional debounce, rising
// edge pulse), then seeds/steps an external LFSR and fills decimal digit slots
// by rejection sampling of the low nibble.
// Build option: define RNG_KEY_DEBOUNCE_EN to include the debouncer; without it
// the edge detector acts directly on the synchronized key levels.
module rng_draw_ctrl #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned RAND_W    = 8,
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_start,
  input  logic                   key_draw,
  input  logic [RAND_W-1:0]      rand_in,
  output logic                   lfsr_en,
  output logic                   lfsr_load,
  output logic [RAND_W-1:0]      seed,
  output logic [4*NUM_SLOTS-1:0] digits,
  output logic [3:0]             draw_cnt,
  output logic                   draw_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Index 0 = start key, index 1 = draw key
  logic [1:0]        w_key;
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        w_lvl;
  logic [1:0]        r_lvl_d;
  logic [1:0]        r_pulse;
  logic              w_start_p;
  logic              w_draw_p;
  logic [RAND_W-1:0] r_free;
  logic [RAND_W-1:0] w_seed;
  logic [3:0]        w_nib;
  logic [3:0]        w_cnt_inc;
  logic              w_accept;
  logic              w_unused_rand;
  state_t            r_state;
  state_t            w_state_nx;

  assign w_key         = {key_draw, key_start};
  assign w_nib         = rand_in[3:0];
  assign w_unused_rand = ^rand_in[RAND_W-1:4];
  assign w_cnt_inc     = draw_cnt + 4'd1;

  // Two-flop synchronizer for both asynchronous key levels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RNG_KEY_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CNT_W-1:0] r_db_cnt [2];
  logic [1:0]       r_db;

  // Debounce: accept a level change only after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db <= '0;
      for (int unsigned k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_db;
`else
  assign w_lvl = r_sync2;
`endif

  // Registered rising-edge pulse on the conditioned key level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl_d <= '0;
      r_pulse <= '0;
    end else begin
      r_lvl_d <= w_lvl;
      r_pulse <= w_lvl & ~r_lvl_d;
    end
  end

  assign w_start_p = r_pulse[0];
  assign w_draw_p  = r_pulse[1];

  // Free-running entropy counter used as the seed source
  always_ff @(posedge clk) begin
    if (rst) r_free <= '0;
    else     r_free <= r_free + 1'b1;
  end

  // A zero seed would lock the LFSR, so substitute 1
  assign w_seed = (r_free == '0) ? RAND_W'(1) : r_free;
  assign seed   = lfsr_load ? w_seed : '0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and control outputs; start pulse has priority everywhere
  always_comb begin
    w_state_nx = r_state;
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_p) w_state_nx = ST_SEED;
      end
      ST_SEED: begin
        lfsr_load  = 1'b1;
        busy       = 1'b1;
        w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        busy    = 1'b1;
        if (w_start_p)     w_state_nx = ST_SEED;
        else if (w_draw_p) w_state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        lfsr_en = 1'b1;
        busy    = 1'b1;
        if (w_start_p) begin
          w_state_nx = ST_SEED;
        end else if (w_nib <= 4'(DIGIT_MAX)) begin
          w_accept   = 1'b1;
          w_state_nx = (w_cnt_inc == 4'(NUM_SLOTS)) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_start_p)     w_state_nx = ST_SEED;
        else if (w_draw_p) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign draw_valid = w_accept;

  // Digit slots and draw counter; slot index bounded by NUM_SLOTS
  always_ff @(posedge clk) begin
    if (rst) begin
      digits   <= '0;
      draw_cnt <= '0;
    end else if (r_state == ST_SEED) begin
      digits   <= '0;
      draw_cnt <= '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        if (draw_cnt == 4'(k)) digits[4*k +: 4] <= w_nib;
      end
      draw_cnt <= w_cnt_inc;
    end else if (r_state == ST_DONE && !w_start_p && w_draw_p) begin
      draw_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_rng_draw_ctrl.sv
// Testbench for rng_draw_ctrl: randomized key/LFSR stimulus checked against a
// round-level model (expected digit list, slot count, key-to-pulse latency).
module tb_rng_draw_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned NS   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned DMAX = 9;
`ifdef RNG_KEY_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_start = 1'b0;
  logic          key_draw = 1'b0;
  logic [RW-1:0] rand_in = '0;
  logic          lfsr_en, lfsr_load, draw_valid, busy, done;
  logic [RW-1:0] seed;
  logic [4*NS-1:0] digits;
  logic [3:0]    draw_cnt;

  int checks = 0;
  int errors = 0;
  int m_free = 0;
  int exp_cnt = 0;
  logic [4*NS-1:0] exp_digits = '0;
  logic [7:0] rej_tab[$];

  rng_draw_ctrl #(.DB_CYCLES(DB), .NUM_SLOTS(NS), .RAND_W(RW), .DIGIT_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_draw(key_draw),
    .rand_in(rand_in), .lfsr_en(lfsr_en), .lfsr_load(lfsr_load), .seed(seed),
    .digits(digits), .draw_cnt(draw_cnt), .draw_valid(draw_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Entropy counter model: cycles since reset release, modulo 2^RW
  always @(posedge clk) begin
    if (rst) m_free <= 0;
    else     m_free <= (m_free + 1) % 256;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rej_val();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(10, 15))};
  endfunction

  function automatic logic [7:0] acc_val(input int d);
    return {4'($urandom_range(0, 15)), 4'(d)};
  endfunction

  function automatic logic [7:0] exp_seed();
    return (m_free == 0) ? 8'd1 : 8'(m_free);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc();
      key_start = 1'($urandom_range(0, 1));
      key_draw  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({lfsr_en, lfsr_load, seed, digits, draw_cnt, draw_valid, busy, done} !== '0)
        begin errors++; $display("FAIL reset_outputs got %h want 0",
          {lfsr_en, lfsr_load, seed, digits, draw_cnt, draw_valid, busy, done}); end
    end
    rst = 1'b0; key_start = 1'b0; key_draw = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if ({lfsr_load, busy, draw_valid} !== 3'b000)
        begin errors++; $display("FAIL reset_no_pulse got %b want 000", {lfsr_load, busy, draw_valid}); end
    end
  endtask

  task automatic test_start_hold();
    key_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (lfsr_load !== (i == LAT + 1))
        begin errors++; $display("FAIL start_load cyc %0d got %b want %b", i, lfsr_load, (i == LAT + 1)); end
      checks++;
      if (busy !== (i >= LAT + 1))
        begin errors++; $display("FAIL start_busy cyc %0d got %b want %b", i, busy, (i >= LAT + 1)); end
      if (i == LAT + 1) begin
        checks++;
        if (seed !== exp_seed())
          begin errors++; $display("FAIL start_seed got %h want %h", seed, exp_seed()); end
      end
    end
    key_start = 1'b0;
    exp_cnt = 0; exp_digits = '0;
    repeat (LAT + 2) cyc();
    @(negedge clk);
    checks++;
    if ({lfsr_en, busy, lfsr_load, draw_cnt, digits} !== {1'b1, 1'b1, 1'b0, 4'd0, 16'h0})
      begin errors++; $display("FAIL start_run got %h want run state", {lfsr_en, busy, lfsr_load, draw_cnt, digits}); end
  endtask

  task automatic press_start();
    key_start = 1'b1;
    repeat (LAT + 1) cyc();
    @(negedge clk);
    checks++;
    if (lfsr_load !== 1'b1 || seed !== exp_seed())
      begin errors++; $display("FAIL seed_pulse got load=%b seed=%h want load=1 seed=%h", lfsr_load, seed, exp_seed()); end
    key_start = 1'b0;
    exp_cnt = 0; exp_digits = '0;
    cyc();
    @(negedge clk);
    checks++;
    if ({lfsr_en, busy, lfsr_load, draw_cnt, digits} !== {1'b1, 1'b1, 1'b0, 4'd0, 16'h0})
      begin errors++; $display("FAIL seed_to_run got %h want run state", {lfsr_en, busy, lfsr_load, draw_cnt, digits}); end
    repeat (LAT + 1) cyc();
  endtask

  task automatic do_draw(input int nrej, input int digit);
    key_draw = 1'b1;
    rand_in  = rej_val();
    repeat (LAT + 1) cyc();
    key_draw = 1'b0;
    for (int r = 0; r <= nrej; r++) begin
      if (r < nrej) rand_in = (rej_tab.size() > 0) ? rej_tab.pop_front() : rej_val();
      else          rand_in = acc_val(digit);
      @(negedge clk);
      checks++;
      if (draw_valid !== (r == nrej) || busy !== 1'b1 || lfsr_en !== 1'b1)
        begin errors++; $display("FAIL sample r=%0d got valid=%b busy=%b en=%b want valid=%b busy=1 en=1",
          r, draw_valid, busy, lfsr_en, (r == nrej)); end
      cyc();
    end
    exp_digits[4*exp_cnt +: 4] = 4'(digit);
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (draw_cnt !== 4'(exp_cnt) || digits !== exp_digits)
      begin errors++; $display("FAIL draw_store got cnt=%0d dig=%h want cnt=%0d dig=%h",
        draw_cnt, digits, exp_cnt, exp_digits); end
    checks++;
    if (done !== (exp_cnt == NS) || busy !== (exp_cnt != NS) || lfsr_en !== (exp_cnt != NS) || draw_valid !== 1'b0)
      begin errors++; $display("FAIL draw_state got done=%b busy=%b en=%b valid=%b cnt=%0d",
        done, busy, lfsr_en, draw_valid, exp_cnt); end
    repeat (LAT + 1) cyc();
  endtask

  task automatic test_reject();
    press_start();
    rej_tab = '{8'h0C, 8'h1F, 8'h2A};
    do_draw(3, 7);
    checks++;
    if (digits[3:0] !== 4'd7)
      begin errors++; $display("FAIL reject_digit got %h want 7", digits[3:0]); end
  endtask

  task automatic test_fill();
    press_start();
    do_draw($urandom_range(0, 2), 3);
    do_draw($urandom_range(0, 2), 0);
    do_draw($urandom_range(0, 2), 9);
    do_draw($urandom_range(0, 2), 5);
    @(negedge clk);
    checks++;
    if ({digits, done, busy, lfsr_en} !== {16'h5903, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL fill_done got dig=%h done=%b busy=%b en=%b want 5903 1 0 0",
        digits, done, busy, lfsr_en); end
    key_draw = 1'b1;
    repeat (LAT + 1) cyc();
    key_draw = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    checks++;
    if ({draw_cnt, digits, done, busy, lfsr_en} !== {4'd0, 16'h5903, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL fill_idle got cnt=%0d dig=%h done=%b busy=%b en=%b want 0 5903 0 0 0",
        draw_cnt, digits, done, busy, lfsr_en); end
    repeat (LAT + 1) cyc();
  endtask

  task automatic test_start_wins();
    press_start();
    do_draw($urandom_range(0, 3), $urandom_range(0, 9));
    do_draw($urandom_range(0, 3), $urandom_range(0, 9));
    key_start = 1'b1;
    key_draw  = 1'b1;
    rand_in   = acc_val($urandom_range(0, 9));
    repeat (LAT + 1) cyc();
    @(negedge clk);
    checks++;
    if (lfsr_load !== 1'b1 || draw_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL wins_seed got load=%b valid=%b busy=%b want 1 0 1", lfsr_load, draw_valid, busy); end
    key_start = 1'b0; key_draw = 1'b0;
    exp_cnt = 0; exp_digits = '0;
    cyc();
    @(negedge clk);
    checks++;
    if ({lfsr_en, draw_cnt, digits, draw_valid, lfsr_load} !== {1'b1, 4'd0, 16'h0, 1'b0, 1'b0})
      begin errors++; $display("FAIL wins_run got %h want run with cleared slots",
        {lfsr_en, draw_cnt, digits, draw_valid, lfsr_load}); end
    repeat (LAT + 1) cyc();
  endtask

  task automatic test_random_rounds();
    for (int rnd = 0; rnd < 2; rnd++) begin
      press_start();
      for (int d = 0; d < NS; d++) do_draw($urandom_range(0, 3), $urandom_range(0, DMAX));
    end
  endtask

  task automatic test_reset_mid();
    press_start();
    do_draw($urandom_range(0, 2), $urandom_range(1, 9));
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if ({lfsr_en, lfsr_load, seed, digits, draw_cnt, draw_valid, busy, done} !== '0)
      begin errors++; $display("FAIL reset_mid got %h want 0",
        {lfsr_en, lfsr_load, seed, digits, draw_cnt, draw_valid, busy, done}); end
    rst = 1'b0;
    exp_cnt = 0; exp_digits = '0;
    repeat (LAT + 1) cyc();
  endtask

  task automatic test_bounce();
    int n_valid;
    n_valid = 0;
    press_start();
    for (int i = 0; i < 20 + LAT + 4; i++) begin
      key_draw = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      rand_in  = acc_val($urandom_range(0, 9));
      cyc();
      @(negedge clk);
      if (draw_valid === 1'b1) n_valid++;
    end
`ifdef RNG_KEY_DEBOUNCE_EN
    checks++;
    if (n_valid !== 0)
      begin errors++; $display("FAIL bounce_count got %0d want 0", n_valid); end
    checks++;
    if ({busy, lfsr_en, done, draw_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0})
      begin errors++; $display("FAIL bounce_state got %h want run", {busy, lfsr_en, done, draw_cnt}); end
`else
    // Five raw rises: four fill the round, the fifth returns DONE to IDLE
    checks++;
    if (n_valid !== NS)
      begin errors++; $display("FAIL bounce_count got %0d want %0d", n_valid, NS); end
    checks++;
    if ({busy, lfsr_en, done, draw_cnt} !== {1'b0, 1'b0, 1'b0, 4'd0})
      begin errors++; $display("FAIL bounce_state got %h want idle", {busy, lfsr_en, done, draw_cnt}); end
`endif
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_reject();
    test_fill();
    test_start_wins();
    test_random_rounds();
    test_reset_mid();
    test_bounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
